// File: rtl/proc_pkg.sv
// Shared opcodes, control-state encoding and instruction-field helpers for the
// multicycle bus processor.
package proc_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_MV   = 4'd0;
  localparam logic [OP_W-1:0] OP_MVI  = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OP_W-1:0] OP_AND  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd7;
  localparam logic [OP_W-1:0] OP_MVNZ = 4'd8;
  localparam logic [OP_W-1:0] OP_OR   = 4'd9;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd10;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // IR layout is {op, rx, ry}; field LSBs depend on the register-address width.
  localparam int IR_RY_LSB = 0;

  function automatic int ir_rx_lsb(input int raw);
    return raw;
  endfunction

  function automatic int ir_op_lsb(input int raw);
    return 2 * raw;
  endfunction

  function automatic logic op_is_alu(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL, OP_SRL, OP_OR, OP_XOR};
  endfunction

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: modulo-2^DW arithmetic, unsigned compare, logical shifts
// whose amount is the full B operand.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [OP_W-1:0] op,
  output logic [DW-1:0]   result
);

  localparam logic [DW-1:0] SHIFT_LIM = DW'(DW);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_SLT: result = {{(DW-1){1'b0}}, (a < b)};
      OP_SLL: result = (b >= SHIFT_LIM) ? '0 : (a << b);
      OP_SRL: result = (b >= SHIFT_LIM) ? '0 : (a >> b);
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/param_processor.sv
// Multicycle single-bus processor: fetch in T0, execute over T1..T3, Done on the
// final cycle. Resetn is a synchronous active-high reset despite its name.
module param_processor
  import proc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Run,
  input  logic [DW-1:0] DIN,
  output logic          Done,
  output logic          Busy,
  output logic          IllegalOp,
  output logic          Zero,
  output logic [DW-1:0] BusWires
);

  localparam int RAW = $clog2(NREG);
  localparam int IRW = OP_W + 2 * RAW;

  state_t          state_q, state_d;
  logic [IRW-1:0]  ir_q, ir_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   g_q, g_d;
  logic            zero_q, zero_d;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];

  logic [OP_W-1:0] op;
  logic [RAW-1:0]  rx, ry;
  logic [DW-1:0]   bus;
  logic [DW-1:0]   alu_res;
  logic            wr_en;
  logic [NREG-1:0] wr_sel;
  logic            single_cycle;

  assign op = ir_q[ir_op_lsb(RAW) +: OP_W];
  assign rx = ir_q[ir_rx_lsb(RAW) +: RAW];
  assign ry = ir_q[IR_RY_LSB +: RAW];

  generate
    if (DW > IRW) begin : g_din_upper
      logic unused_din_upper;
      assign unused_din_upper = ^DIN[DW-1:IRW];
    end
  endgenerate

  // Exactly one bus source per control state; nothing drives it while in reset.
  always_comb begin
    bus = '0;
    case (state_q)
      T1: begin
        if (op == OP_MVI) begin
          bus = DIN;
        end else if (op == OP_MV || op == OP_MVNZ) begin
          bus = regs_q[ry];
        end else if (op_is_alu(op)) begin
          bus = regs_q[rx];
        end
      end
      T2: bus = regs_q[ry];
      T3: bus = g_q;
      default: bus = '0;
    endcase
    if (Resetn) begin
      bus = '0;
    end
  end

  proc_alu #(.DW(DW)) u_alu (
    .a      (a_q),
    .b      (bus),
    .op     (op),
    .result (alu_res)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    zero_d  = zero_q;
    wr_en   = 1'b0;
    case (state_q)
      T0: begin
        if (Run) begin
          ir_d    = DIN[IRW-1:0];
          state_d = T1;
        end
      end
      T1: begin
        state_d = T0;
        if (op == OP_MV || op == OP_MVI) begin
          wr_en = 1'b1;
        end else if (op == OP_MVNZ) begin
          wr_en = (g_q != '0);
        end else if (op_is_alu(op)) begin
          a_d     = bus;
          state_d = T2;
        end
      end
      T2: begin
        g_d     = alu_res;
        zero_d  = (alu_res == '0);
        state_d = T3;
      end
      T3: begin
        wr_en   = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regfile
      localparam logic [RAW-1:0] IDX = RAW'(gi);
      assign wr_sel[gi] = wr_en && (rx == IDX);
      assign regs_d[gi] = wr_sel[gi] ? bus : regs_q[gi];
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      zero_q  <= 1'b1;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      zero_q  <= zero_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign single_cycle = (op == OP_MV) || (op == OP_MVI) || (op == OP_MVNZ) || !op_is_legal(op);

  assign Done      = !Resetn && ((state_q == T1 && single_cycle) || state_q == T3);
  assign IllegalOp = !Resetn && (state_q == T1) && !op_is_legal(op);
  assign Busy      = !Resetn && (state_q != T0);
  assign Zero      = zero_q;
  assign BusWires  = bus;

endmodule

// File: tb/tb_param_processor.sv
// Randomised bench for param_processor: an instruction-level model predicts the bus,
// Done, Busy, IllegalOp and Zero for every cycle; a compare process checks them.
module tb_param_processor;
  import proc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, run_a, done_a, busy_a, ill_a, zero_a;
  logic [15:0] din_a, bus_a;
  logic        rst_b, run_b, done_b, busy_b, ill_b, zero_b;
  logic [31:0] din_b, bus_b;

  param_processor #(.DW(16), .NREG(8)) dut_a (
    .Clock(clk), .Resetn(rst_a), .Run(run_a), .DIN(din_a), .Done(done_a),
    .Busy(busy_a), .IllegalOp(ill_a), .Zero(zero_a), .BusWires(bus_a)
  );

  param_processor #(.DW(32), .NREG(16)) dut_b (
    .Clock(clk), .Resetn(rst_b), .Run(run_b), .DIN(din_b), .Done(done_b),
    .Busy(busy_b), .IllegalOp(ill_b), .Zero(zero_b), .BusWires(bus_b)
  );

  typedef struct {
    logic [31:0] bus;
    logic        done;
    logic        busy;
    logic        ill;
    logic        zero;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          sel = 0;
  int          cur_dw = 16;
  int          cur_raw = 3;
  int          cur_nreg = 8;
  logic [31:0] m_regs [16];
  logic [31:0] m_g;
  logic        m_zero;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_of();
    return (cur_dw == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic bit is_alu_op(input int op);
    return (op >= 2 && op <= 7) || op == 9 || op == 10;
  endfunction

  function automatic logic [31:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = 64'd0;
    case (op)
      2:  r = 64'(a) + 64'(b);
      3:  r = 64'(a) - 64'(b);
      4:  r = 64'(a & b);
      5:  r = (a < b) ? 64'd1 : 64'd0;
      6:  r = (b >= 32'(cur_dw)) ? 64'd0 : (64'(a) << b);
      7:  r = (b >= 32'(cur_dw)) ? 64'd0 : (64'(a) >> b);
      9:  r = 64'(a | b);
      10: r = 64'(a ^ b);
      default: r = 64'd0;
    endcase
    return r[31:0] & mask_of();
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_g = 32'd0;
    m_zero = 1'b1;
  endtask

  task automatic drive(input bit run, input logic [31:0] din);
    if (sel == 0) begin
      run_a = run;
      din_a = din[15:0];
    end else begin
      run_b = run;
      din_b = din;
    end
  endtask

  task automatic set_rst(input bit r);
    if (sel == 0) rst_a = r;
    else rst_b = r;
  endtask

  task automatic push(input logic [31:0] bus, input logic done, input logic busy, input logic ill);
    exp_t e;
    e.bus  = bus & mask_of();
    e.done = done;
    e.busy = busy;
    e.ill  = ill;
    e.zero = m_zero;
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] encode(input int op, input int rx, input int ry);
    int nb;
    logic [31:0] w;
    nb = 4 + 2 * cur_raw;
    w = $urandom() & mask_of();
    w = ((w >> nb) << nb) | 32'(op << (2 * cur_raw)) | 32'(rx << cur_raw) | 32'(ry);
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, $urandom());
      push(32'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  // One full instruction: fetch cycle plus its execute cycles, updating the model.
  task automatic issue(input int op, input int rx, input int ry, input logic [31:0] imm);
    logic [31:0] a, b;
    drive(1'b1, encode(op, rx, ry));
    push(32'd0, 1'b0, 1'b0, 1'b0);
    step();
    if (op == 0) begin
      drive(1'($urandom()), $urandom());
      push(m_regs[ry], 1'b1, 1'b1, 1'b0);
      m_regs[rx] = m_regs[ry];
      step();
    end else if (op == 1) begin
      drive(1'($urandom()), imm);
      push(imm, 1'b1, 1'b1, 1'b0);
      m_regs[rx] = imm & mask_of();
      step();
    end else if (op == 8) begin
      drive(1'($urandom()), $urandom());
      push(m_regs[ry], 1'b1, 1'b1, 1'b0);
      if (m_g != 32'd0) m_regs[rx] = m_regs[ry];
      step();
    end else if (is_alu_op(op)) begin
      a = m_regs[rx];
      drive(1'($urandom()), $urandom());
      push(a, 1'b0, 1'b1, 1'b0);
      step();
      b = m_regs[ry];
      drive(1'($urandom()), $urandom());
      push(b, 1'b0, 1'b1, 1'b0);
      step();
      m_g = alu_model(op, a, b);
      m_zero = (m_g == 32'd0);
      drive(1'($urandom()), $urandom());
      push(m_g, 1'b1, 1'b1, 1'b0);
      m_regs[rx] = m_g;
      step();
    end else begin
      drive(1'($urandom()), $urandom());
      push(32'd0, 1'b1, 1'b1, 1'b1);
      step();
    end
  endtask

  task automatic read_all();
    for (int r = 0; r < cur_nreg; r++) issue(0, r, r, 32'd0);
  endtask

  task automatic random_run(input int n);
    repeat (n) begin
      issue($urandom_range(0, 15), $urandom_range(0, cur_nreg - 1),
            $urandom_range(0, cur_nreg - 1), $urandom());
    end
  endtask

  task automatic arith_test();
    issue(1, 0, 0, 32'd5);
    issue(1, 1, 0, 32'd3);
    issue(2, 0, 1, 32'd0);
    chk("add_r0", m_regs[0], 32'd8);
    issue(3, 1, 1, 32'd0);
    chk("sub_self_r1", m_regs[1], 32'd0);
    chk("sub_self_zero", 32'(m_zero), 32'd1);
    issue(1, 2, 0, 32'd0);
    issue(1, 3, 0, 32'd1);
    issue(3, 2, 3, 32'd0);
    chk("sub_wrap", m_regs[2], (cur_dw == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF);
    read_all();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      if (sel == 0) begin
        chk("bus", {16'd0, bus_a}, e.bus);
        chk("done", 32'(done_a), 32'(e.done));
        chk("busy", 32'(busy_a), 32'(e.busy));
        chk("illegal", 32'(ill_a), 32'(e.ill));
        chk("zero", 32'(zero_a), 32'(e.zero));
      end else begin
        chk("bus_w", bus_b, e.bus);
        chk("done_w", 32'(done_b), 32'(e.done));
        chk("busy_w", 32'(busy_b), 32'(e.busy));
        chk("illegal_w", 32'(ill_b), 32'(e.ill));
        chk("zero_w", 32'(zero_b), 32'(e.zero));
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    run_a = 1'b0; run_b = 1'b0;
    din_a = '0;   din_b = '0;
    model_reset();
    step(); step();
    rst_a = 1'b0;

    // Reset state, then idle with Run low.
    idle(5);
    read_all();

    // mvi / mv with the literal fetch word.
    drive(1'b1, 32'h0000_0040);
    push(32'd0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0000_0005);
    push(32'd5, 1'b1, 1'b1, 1'b0);
    m_regs[0] = 32'd5;
    step();
    issue(0, 1, 0, 32'd0);
    chk("mv_r1", m_regs[1], 32'd5);

    arith_test();

    // slt and shift boundaries.
    issue(1, 4, 0, 32'd2); issue(1, 5, 0, 32'd7); issue(5, 4, 5, 32'd0);
    chk("slt_2_7", m_regs[4], 32'd1);
    issue(1, 4, 0, 32'd7); issue(1, 6, 0, 32'd2); issue(5, 4, 6, 32'd0);
    chk("slt_7_2", m_regs[4], 32'd0);
    issue(1, 4, 0, 32'hABCD); issue(1, 5, 0, 32'd20); issue(6, 4, 5, 32'd0);
    chk("sll_20", m_regs[4], 32'd0);
    issue(1, 4, 0, 32'h8000); issue(1, 5, 0, 32'd15); issue(7, 4, 5, 32'd0);
    chk("srl_15", m_regs[4], 32'd1);

    // mvnz with G zero / non-zero, then an illegal opcode.
    issue(3, 7, 7, 32'd0);
    issue(1, 6, 0, 32'd9); issue(1, 5, 0, 32'h55);
    issue(8, 6, 5, 32'd0);
    chk("mvnz_g0", m_regs[6], 32'd9);
    issue(1, 0, 0, 32'd5); issue(1, 1, 0, 32'd3); issue(2, 0, 1, 32'd0);
    chk("g_is_8", m_g, 32'd8);
    issue(8, 6, 5, 32'd0);
    chk("mvnz_g8", m_regs[6], 32'h55);
    issue(12, 3, 4, 32'd0);
    read_all();

    random_run(150);
    read_all();

    // Reset asserted during an ALU op's T2 abandons it.
    issue(1, 0, 0, 32'd5); issue(1, 1, 0, 32'd3);
    drive(1'b1, encode(2, 0, 1));
    push(32'd0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0);
    push(m_regs[0], 1'b0, 1'b1, 1'b0);
    step();
    set_rst(1'b1);
    push(32'd0, 1'b0, 1'b0, 1'b0);
    step();
    set_rst(1'b0);
    model_reset();
    idle(2);
    read_all();
    idle(2);

    // Wide configuration: DW=32, NREG=16.
    sel = 1; cur_dw = 32; cur_raw = 4; cur_nreg = 16;
    run_a = 1'b0;
    step();
    rst_b = 1'b0;
    model_reset();
    idle(3);
    arith_test();
    random_run(100);
    read_all();
    idle(2);

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain t=%0t actual=%0d required=0", $time, expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
